store_rmw_unit: RTL
===================

Name: store_rmw_unit

Overview:
- Write-side counterpart of the immediate/load sign-extension path.
- Takes a 32-bit register value plus a store size (byte/half/word) and narrows it into the correct byte lane(s) of a 32-bit word memory.
- Byte and halfword stores are done as a read-modify-write over a single-port, word-only data memory; word stores go straight to a write.
- Sits between the CPU's MEM stage and the data memory; the CPU stalls on req_ready_o/done_o.

Parameters:
ADDR_W, 32, byte-address width; memory address is word-aligned (low 2 bits forced to 0)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_valid_i  in  1  store request present
req_ready_o  out  1  unit idle and able to accept a request
addr_i  in  ADDR_W  byte address of the store
wdata_i  in  32  register data; only the low byte/half is used for narrow stores
size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
done_o  out  1  one-cycle pulse when the request has completed
err_o  out  1  one-cycle pulse with done_o on a misaligned or reserved-size request
mem_addr_o  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
mem_rd_o  out  1  read strobe, held until mem_rvalid_i
mem_rdata_i  in  32  read data
mem_rvalid_i  in  1  read data valid
mem_wr_o  out  1  write strobe, held until mem_ack_i
mem_wdata_o  out  32  merged write word
mem_ack_i  in  1  write accepted

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- req_ready_o = (state==IDLE). A request is accepted on the clock edge where req_valid_i && req_ready_o; addr, wdata and size are latched at that edge.
- IDLE transitions on accept:
  - word, addr[1:0]==00 -> WRITE
  - byte -> READ
  - half with addr[0]==0 -> READ
  - half with addr[0]==1, word with addr[1:0]!=00, or size 11 -> DONE with err flagged; no memory strobe is ever raised for these.
- READ: mem_rd_o=1 and mem_addr_o valid. When mem_rvalid_i is sampled high (a same-cycle response is legal), latch mem_rdata_i and go to WRITE. There is no timeout; READ waits indefinitely.
- WRITE: mem_wr_o=1, mem_wdata_o = merged word. When mem_ack_i is high, go to DONE. Waits indefinitely.
- DONE: done_o=1 for exactly one cycle, err_o = latched error flag, then return to IDLE. A new request can be accepted on the cycle after DONE.
- Merge rules (little-endian):
  - byte k = addr[1:0] replaces bits [8k+7:8k] with wdata[7:0]; all other bits come from the latched read word.
  - half: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0].
  - word: mem_wdata_o = wdata.
- Latency with zero-wait memory, cycle 0 = accept edge:
  - word: mem_wr_o in cycle 1, done_o in cycle 2.
  - byte/half: mem_rd_o in cycle 1, mem_wr_o in cycle 2, done_o in cycle 3.
  - error: done_o+err_o in cycle 1.
- Strobes are registered outputs, decoded from state only. mem_rd_o and mem_wr_o are never high together.
- Outputs are stable while a strobe waits for its response.
- Reset (rst_i low, at any time including mid-transaction):
  - state goes to IDLE immediately; mem_rd_o, mem_wr_o, done_o, err_o = 0; mem_addr_o, mem_wdata_o = 0; req_ready_o = 1.
  - An in-flight read or write is abandoned. Memory responses arriving after reset are ignored because IDLE does not sample them.
- mem_rvalid_i / mem_ack_i seen outside READ/WRITE are ignored.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding constants for IDLE/READ/WRITE/DONE
- Sub-module store_lane_merge, purely combinational: inputs old word, wdata, size, addr[1:0]; output merged 32-bit word. It is reusable by a later load-side lane-extract block.

Test Plan:
1. Word store addr=0x0000_0010, wdata=0xDEADBEEF, zero-wait mem -> no mem_rd_o; mem_wr_o cycle 1 with mem_wdata_o=0xDEADBEEF; done_o cycle 2, err_o=0.
2. Byte store addr=0x0000_0013, wdata=0x1234_56AB, memory returns 0x1122_3344 -> mem_addr_o=0x0000_0010; mem_wdata_o=0xAB22_3344; done_o cycle 3.
3. Half store addr=0x0000_0006, wdata=0xFFFF_8001, old word 0xAAAA_BBBB, mem_rvalid_i delayed 3 cycles and mem_ack_i delayed 2 cycles -> mem_rd_o held 4 cycles, mem_wr_o held 3 cycles with 0x8001_BBBB; a single done_o pulse.
4. Misaligned half at 0x0000_0005, word at 0x0000_0002, and size 11 -> each gives done_o=err_o=1 in cycle 1, with mem_rd_o and mem_wr_o never asserted.
5. Reset asserted while in WRITE, with mem_ack_i not yet given -> mem_wr_o drops asynchronously, no done_o; after release req_ready_o=1; a late mem_ack_i is ignored; the next word store completes normally.
6. Back-to-back requests with req_valid_i held high -> the second is accepted the cycle after the first's done_o; the two transactions do not overlap.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared encodings for the store read-modify-write path: access sizes,
// FSM state encoding and request classification helpers.
package store_rmw_unit_pkg;

  // Access size encodings as presented on size_i
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_READ_ENC  = 2'b01;
  localparam logic [1:0] ST_WRITE_ENC = 2'b10;
  localparam logic [1:0] ST_DONE_ENC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_READ  = ST_READ_ENC,
    ST_WRITE = ST_WRITE_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  // A request is rejected when it is misaligned for its size or uses the
  // reserved size code; such requests never touch memory.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] byte_off);
    logic err;
    unique case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = byte_off[0];
      SZ_WORD: err = (byte_off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: places the low byte/half/word of
// wdata into the lane(s) selected by size and byte offset, keeping the rest
// of old_word. Kept standalone so the load side can mirror its lane decode.
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged
);

  logic [31:0] src_word;
  logic [3:0]  lane_en;

  // Replicate the narrow data into every lane so each lane just selects
  always_comb begin
    src_word = wdata;
    unique case (size)
      SZ_BYTE: src_word = {4{wdata[7:0]}};
      SZ_HALF: src_word = {2{wdata[15:0]}};
      default: src_word = wdata;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);

    assign lane_en[gi] = ((size == SZ_BYTE) && (byte_off == LANE)) ||
                         ((size == SZ_HALF) && (byte_off[1] == LANE[1])) ||
                         (size == SZ_WORD);

    assign merged[8*gi +: 8] = lane_en[gi] ? src_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store narrowing unit: word stores write directly, byte/half stores do a
// read-modify-write of the containing word over a word-only memory port.
// Misaligned or reserved-size requests complete with err_o and no memory
// traffic. All memory strobes and status pulses are registered.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [1:0]        byte_off_reg, byte_off_next;
  logic [1:0]        size_reg, size_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic              done_reg, done_next;
  logic              err_out_reg, err_out_next;
  logic [31:0]       merged_word;

  // Merge reads the memory data directly so the merged word can be captured
  // on the same edge the read response is accepted.
  store_lane_merge u_merge (
    .old_word (mem_rdata_i),
    .wdata    (wdata_reg),
    .size     (size_reg),
    .byte_off (byte_off_reg),
    .merged   (merged_word)
  );

  // Next-state, request capture and registered-output decode
  always_comb begin
    state_next     = state_reg;
    mem_addr_next  = mem_addr_reg;
    byte_off_next  = byte_off_reg;
    size_next      = size_reg;
    wdata_next     = wdata_reg;
    err_next       = err_reg;
    mem_wdata_next = mem_wdata_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          mem_addr_next = {addr_i[ADDR_W-1:2], 2'b00};
          byte_off_next = addr_i[1:0];
          size_next     = size_i;
          wdata_next    = wdata_i;
          err_next      = req_is_err(size_i, addr_i[1:0]);
          if (req_is_err(size_i, addr_i[1:0])) begin
            state_next = ST_DONE;
          end else if (size_i == SZ_WORD) begin
            mem_wdata_next = wdata_i;
            state_next     = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_rvalid_i) begin
          mem_wdata_next = merged_word;
          state_next     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack_i) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are flop outputs
    mem_rd_next  = (state_next == ST_READ);
    mem_wr_next  = (state_next == ST_WRITE);
    done_next    = (state_next == ST_DONE);
    err_out_next = (state_next == ST_DONE) && err_next;
  end

  // State and output registers, cleared asynchronously to abandon any access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= ST_IDLE;
      mem_addr_reg  <= '0;
      byte_off_reg  <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      mem_wdata_reg <= '0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      byte_off_reg  <= byte_off_next;
      size_reg      <= size_next;
      wdata_reg     <= wdata_next;
      err_reg       <= err_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_rd_reg    <= mem_rd_next;
      mem_wr_reg    <= mem_wr_next;
      done_reg      <= done_next;
      err_out_reg   <= err_out_next;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign done_o      = done_reg;
  assign err_o       = err_out_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_rd_o    = mem_rd_reg;
  assign mem_wr_o    = mem_wr_reg;
  assign mem_wdata_o = mem_wdata_reg;

endmodule
